// File: rtl/packet_egress_queue_if.sv
// Consumer-side handshake of packet_egress_queue.
//   out_pkt   : 13-bit simple packet at the FIFO head
//   out_prio  : priority of the head entry
//   out_valid : head entry present
//   out_ready : consumer accepts the head this cycle
// master = queue side, slave = consumer side.
interface packet_egress_queue_if;
  logic [12:0] out_pkt;
  logic [1:0]  out_prio;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_pkt, output out_prio, output out_valid, input out_ready);
  modport slave  (input out_pkt, input out_prio, input out_valid, output out_ready);
endinterface

// File: rtl/packet_egress_queue.sv
// Packet types shared by packet_enhancer and its egress queue.
package packet_egress_queue_pkg;
  typedef struct packed {
    logic       valid;
    logic [3:0] id;
    logic [7:0] data;
  } simple_packet_t;

  typedef struct packed {
    simple_packet_t payload;
    logic [1:0]     prio;
    logic           error;
  } enhanced_packet_t;

  typedef struct packed {
    simple_packet_t pkt;
    logic [1:0]     prio;
  } fifo_entry_t;
endpackage

// packet_egress_queue: filters the enhanced packet stream, buffers good
// packets in a show-ahead FIFO and presents them on a valid/ready handshake.
//   clk, rst      : clock, synchronous active-high reset
//   pkt_in        : enhanced packet sampled every cycle
//   flush         : empties the FIFO, counters kept
//   egress        : head packet / priority / valid / ready
//   level         : occupancy; full / empty derived from it
//   drop_err_cnt  : saturating count of errored packets dropped
//   drop_ovf_cnt  : saturating count of packets dropped on overflow
module packet_egress_queue
  import packet_egress_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  enhanced_packet_t             pkt_in,
  input  logic                         flush,
  packet_egress_queue_if.master        egress,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic [CNT_W-1:0]             drop_err_cnt,
  output logic [CNT_W-1:0]             drop_ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  fifo_entry_t    mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  logic cand;
  logic pop;
  logic push;
  logic drop_err;
  logic drop_ovf;

  // Status flags and show-ahead head presentation.
  assign full             = (level == LW'(DEPTH));
  assign empty            = (level == '0);
  assign egress.out_valid = !empty;
  assign egress.out_pkt   = mem[rd_ptr].pkt;
  assign egress.out_prio  = mem[rd_ptr].prio;

  // Input qualification; flush suppresses both input and pop for the cycle.
  always_comb begin
    cand     = pkt_in.payload.valid & !flush;
    pop      = egress.out_valid & egress.out_ready & !flush;
    drop_err = cand & pkt_in.error;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push     = cand & !pkt_in.error & (!full | pop);
    drop_ovf = cand & !pkt_in.error & full & !pop;
  end

  // Storage is deliberately not reset; only the pointers define content.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= fifo_entry_t'({pkt_in.payload, pkt_in.prio});
    end
  end

  // Pointers, occupancy and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
      // Counters saturate rather than wrap.
      if (drop_err && (drop_err_cnt != {CNT_W{1'b1}})) begin
        drop_err_cnt <= drop_err_cnt + CNT_W'(1);
      end
      if (drop_ovf && (drop_ovf_cnt != {CNT_W{1'b1}})) begin
        drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_packet_egress_queue.sv
// Self-checking bench for packet_egress_queue: two instances (8-bit and
// 2-bit counters) share stimulus and are compared every cycle against a
// queue-based reference model, plus hand-computed directed expectations.
module tb_packet_egress_queue;
  import packet_egress_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst   = 1'b1;
  logic             flush = 1'b0;
  logic             ready = 1'b0;
  enhanced_packet_t pkt_in = '0;

  packet_egress_queue_if if_a ();
  packet_egress_queue_if if_b ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  logic [2:0] level_a, level_b;
  logic       full_a, full_b, empty_a, empty_b;
  logic [7:0] err_a, ovf_a;
  logic [1:0] err_b, ovf_b;

  packet_egress_queue #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .flush(flush), .egress(if_a),
    .level(level_a), .full(full_a), .empty(empty_a),
    .drop_err_cnt(err_a), .drop_ovf_cnt(ovf_a)
  );

  packet_egress_queue #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .flush(flush), .egress(if_b),
    .level(level_b), .full(full_b), .empty(empty_b),
    .drop_err_cnt(err_b), .drop_ovf_cnt(ovf_b)
  );

  // Reference model: a plain queue plus unbounded drop tallies.
  fifo_entry_t mq[$];
  int unsigned m_err = 0;
  int unsigned m_ovf = 0;

  always @(posedge clk) begin
    bit pop_m;
    bit push_m;
    fifo_entry_t e;
    if (rst) begin
      mq.delete();
      m_err = 0;
      m_ovf = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      pop_m  = (mq.size() != 0) && ready;
      push_m = 1'b0;
      if (pkt_in.payload.valid) begin
        if (pkt_in.error)                         m_err++;
        else if ((mq.size() < DEPTH) || pop_m)    push_m = 1'b1;
        else                                      m_ovf++;
      end
      e.pkt  = pkt_in.payload;
      e.prio = pkt_in.prio;
      if (pop_m)  void'(mq.pop_front());
      if (push_m) mq.push_back(e);
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic simple_packet_t mkp(input logic [3:0] id, input logic [7:0] data);
    simple_packet_t p;
    p.valid = 1'b1;
    p.id    = id;
    p.data  = data;
    return p;
  endfunction

  function automatic enhanced_packet_t mke(input logic [3:0] id, input logic [7:0] data,
                                           input logic [1:0] prio, input logic err);
    enhanced_packet_t e;
    e.payload = mkp(id, data);
    e.prio    = prio;
    e.error   = err;
    return e;
  endfunction

  // Every-cycle comparison of both instances against the model.
  task automatic compare_all();
    int unsigned sz;
    sz = mq.size();
    chk("level_a", 32'(level_a), 32'(sz));
    chk("level_b", 32'(level_b), 32'(sz));
    chk("full_a",  32'(full_a),  32'(sz == DEPTH));
    chk("empty_a", 32'(empty_a), 32'(sz == 0));
    chk("full_b",  32'(full_b),  32'(sz == DEPTH));
    chk("empty_b", 32'(empty_b), 32'(sz == 0));
    chk("valid_a", 32'(if_a.out_valid), 32'(sz != 0));
    chk("valid_b", 32'(if_b.out_valid), 32'(sz != 0));
    chk("err_a", 32'(err_a), sat(m_err, 255));
    chk("ovf_a", 32'(ovf_a), sat(m_ovf, 255));
    chk("err_b", 32'(err_b), sat(m_err, 3));
    chk("ovf_b", 32'(ovf_b), sat(m_ovf, 3));
    if (sz != 0) begin
      chk("pkt_a",  32'(if_a.out_pkt),  32'(mq[0].pkt));
      chk("prio_a", 32'(if_a.out_prio), 32'(mq[0].prio));
      chk("pkt_b",  32'(if_b.out_pkt),  32'(mq[0].pkt));
      chk("prio_b", 32'(if_b.out_prio), 32'(mq[0].prio));
    end
  endtask

  // Inputs are applied at the falling edge, outputs checked at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [3:0] drain_ids [4];
    int unsigned thresh;

    // 1. reset then idle
    rst = 1'b1; pkt_in = '0; step();
    rst = 1'b0; step();
    chk("t1_valid", 32'(if_a.out_valid), 32'd0);
    chk("t1_empty", 32'(empty_a), 32'd1);
    chk("t1_level", 32'(level_a), 32'd0);
    chk("t1_err",   32'(err_a), 32'd0);
    chk("t1_ovf",   32'(ovf_a), 32'd0);

    // 2. ordered passthrough with ready held high
    ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pkt_in = mke(4'(i), 8'hAA, 2'b10, 1'b0);
      step();
      chk("t2_pkt",  32'(if_a.out_pkt),  32'(13'h10AA + 13'(i * 256)));
      chk("t2_prio", 32'(if_a.out_prio), 32'd2);
    end
    pkt_in = '0; step();
    chk("t2_drained", 32'(empty_a), 32'd1);

    // 3. errored packet is filtered
    pkt_in = mke(4'h5, 8'h11, 2'b01, 1'b1); step();
    pkt_in = '0;
    chk("t3_err",   32'(err_a), 32'd1);
    chk("t3_level", 32'(level_a), 32'd0);

    // 4. overflow with ready low
    rst = 1'b1; ready = 1'b0; step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pkt_in = mke(4'(i), 8'(8'h30 + i), 2'(i), 1'b0);
      step();
    end
    pkt_in = '0;
    chk("t4_level", 32'(level_a), 32'd4);
    chk("t4_full",  32'(full_a), 32'd1);
    chk("t4_ovf",   32'(ovf_a), 32'd2);
    chk("t4_head0", 32'(if_a.out_pkt), 32'(13'h1030));

    // 5. at full, simultaneous pop and push is accepted
    ready = 1'b1;
    pkt_in = mke(4'h6, 8'h66, 2'b11, 1'b0); step();
    pkt_in = '0;
    chk("t5_level", 32'(level_a), 32'd4);
    chk("t5_ovf",   32'(ovf_a), 32'd2);
    drain_ids = '{4'd1, 4'd2, 4'd3, 4'd6};
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain_id", 32'(if_a.out_pkt[11:8]), 32'(drain_ids[i]));
      step();
    end
    chk("t5_empty", 32'(empty_a), 32'd1);

    // 6a. flush at level 3; input in the flush cycle is ignored
    ready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      pkt_in = mke(4'(i), 8'h5A, 2'b00, 1'b0);
      step();
    end
    chk("t6_level3", 32'(level_a), 32'd3);
    flush = 1'b1; pkt_in = mke(4'hE, 8'hEE, 2'b01, 1'b1); step();
    flush = 1'b0; pkt_in = '0;
    chk("t6_level0", 32'(level_a), 32'd0);
    chk("t6_err",    32'(err_a), 32'd0);
    chk("t6_ovf",    32'(ovf_a), 32'd2);

    // 6b. counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      pkt_in = mke(4'(i), 8'h00, 2'b00, 1'b1);
      step();
    end
    pkt_in = '0;
    chk("t6_sat_b", 32'(err_b), 32'd3);
    chk("t6_cnt_a", 32'(err_a), 32'd5);

    // Randomized phase with varying consumer back-pressure.
    for (int c = 0; c < 3000; c++) begin
      thresh = (c < 1000) ? 20 : ((c < 2000) ? 80 : 50);
      rst    = ($urandom_range(0, 299) == 0);
      flush  = ($urandom_range(0, 49) == 0);
      ready  = ($urandom_range(0, 99) < thresh);
      pkt_in.payload.valid = ($urandom_range(0, 9) < 7);
      pkt_in.payload.id    = 4'($urandom);
      pkt_in.payload.data  = 8'($urandom);
      pkt_in.prio          = 2'($urandom);
      pkt_in.error         = ($urandom_range(0, 9) < 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
